// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues in-order req/gnt/rvalid requests and buffers words toward decode.
// Optional FETCH_PERF_EN adds saturating pop/discard counters (fetch_count_o, drop_count_o).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_count_o,
  output logic [31:0] drop_count_o,
`endif
  output logic [31:0] pc_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = DEPTH[CW:0];

  typedef logic [31:0] data_t;
  typedef struct packed {
    data_t       instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d, outst_q, outst_d, drop_q, drop_d;
  logic [31:0]     req_pc_q, req_pc_d, resp_pc_q, resp_pc_d;
  logic [CW:0]     inflight;
  logic            grant, rsp, push, pop, discard;
  logic [31:0]     redir_pc;

  // Credit counts both in-flight and buffered words, so a push can never overflow.
  assign inflight    = {1'b0, outst_q} + {1'b0, cnt_q};
  assign imem_req_o  = rst_ni && !redirect_i && (inflight < CAP);
  assign imem_addr_o = req_pc_q;
  assign redir_pc    = redirect_pc_i & 32'hFFFF_FFFC;

  assign grant   = imem_req_o && imem_gnt_i;
  assign rsp     = imem_rvalid_i && (outst_q != '0);
  assign discard = rsp && (redirect_i || (drop_q != '0));
  assign push    = rsp && !discard;
  assign pop     = instr_valid_o && instr_ready_i;

  assign instr_valid_o = (cnt_q != '0);
  assign instruction_o = mem_q[rptr_q].instr;
  assign pc_o          = mem_q[rptr_q].pc;

  always_comb begin
    outst_d   = outst_q + CW'(grant) - CW'(rsp);
    drop_d    = drop_q;
    req_pc_d  = req_pc_q;
    resp_pc_d = resp_pc_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    if (redirect_i) begin
      // Everything still in flight belongs to the old path.
      drop_d    = outst_q - CW'(rsp);
      req_pc_d  = redir_pc;
      resp_pc_d = redir_pc;
      wptr_d    = '0;
      rptr_d    = '0;
      cnt_d     = '0;
    end else begin
      if (rsp && drop_q != '0) drop_d = drop_q - CW'(1);
      if (grant) req_pc_d = req_pc_q + 32'd4;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wptr_d    = wptr_q + AW'(1);
      end
      if (pop) rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
      req_pc_q  <= RESET_PC;
      resp_pc_q <= RESET_PC;
    end else begin
      if (push) mem_q[wptr_q] <= '{instr: imem_rdata_i, pc: resp_pc_q};
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      req_pc_q  <= req_pc_d;
      resp_pc_q <= resp_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fcnt_q, dcnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      if (pop && fcnt_q != 32'hFFFF_FFFF) fcnt_q <= fcnt_q + 32'd1;
      if (discard && dcnt_q != 32'hFFFF_FFFF) dcnt_q <= dcnt_q + 32'd1;
    end
  end
  assign fetch_count_o = fcnt_q;
  assign drop_count_o  = dcnt_q;
`endif
endmodule
